arm_mode_ctrl: RTL
==================

// Module: arm_mode_ctrl
// PURPOSE
//  Parametrised mode controller for the robotic arm: selects the joint-position source
//  (live accelerometer mapping, or recorded pose playback) and records pose sequences.
//  Sits between the accelerometer-to-angle mapper and the per-joint servo PWM generators.
//  Adds RECORD/PLAYBACK with on-chip pose memory, N joints, and sample-tick pacing.
// PARAMETERS
//  N_JOINTS  4   number of arm joints (channels)
//  POS_W     8   bits per joint position (unsigned, 0..2^POS_W-1)
//  DEPTH     16  pose memory entries (power of 2, >=2); CNT_W = $clog2(DEPTH)+1
// PORTS
//  clk          in   1                 system clock
//  rst          in   1                 async reset, active-low
//  enable       in   1                 global arm enable; low forces IDLE
//  btn_mem      in   1                 1-cycle pulse (debounced upstream): start/stop playback
//  btn_rec      in   1                 1-cycle pulse: start/stop recording
//  sample_tick  in   1                 1-cycle pacing strobe (pose sample rate)
//  live_pos     in   N_JOINTS*POS_W    live joint targets, joint j at [j*POS_W +: POS_W]
//  cmd_pos      out  N_JOINTS*POS_W    registered joint command to servo PWM
//  cmd_valid    out  1                 1-cycle pulse when cmd_pos updates
//  state        out  2                 0 IDLE, 1 LIVE, 2 RECORD, 3 PLAYBACK
//  mem_count    out  CNT_W             number of valid stored poses (0..DEPTH)
//  err          out  1                 1-cycle pulse: playback requested with empty memory
// BEHAVIOUR
//  Reset: state=IDLE, cmd_pos=all joints 2^(POS_W-1) (mid-travel), cmd_valid=0,
//   mem_count=0, err=0, wr/rd pointers=0. Memory contents not reset.
//  enable=0 in any state: next cycle state=IDLE; cmd_pos holds; mem_count preserved.
//  IDLE: enable=1 & btn_rec -> RECORD (wr_ptr=0, mem_count=0);
//   enable=1 & btn_mem -> PLAYBACK if mem_count>0 (rd_ptr=0), else stay IDLE + err pulse;
//   enable=1, no button -> LIVE. btn_rec has priority over btn_mem when simultaneous.
//  LIVE: on sample_tick, cmd_pos<=live_pos, cmd_valid=1 next cycle. btn_rec -> RECORD,
//   btn_mem -> PLAYBACK/err as in IDLE.
//  RECORD: on sample_tick, mem[wr_ptr]<=live_pos, cmd_pos<=live_pos, wr_ptr++, mem_count++.
//   mem_count reaching DEPTH -> LIVE automatically (no overwrite). btn_rec -> LIVE.
//   btn_mem ignored. btn_rec and sample_tick same cycle: sample written, then exit.
//  PLAYBACK: on sample_tick, cmd_pos<=mem[rd_ptr], rd_ptr++. After entry mem_count-1
//   is output: end-of-sequence action (see CONFIGURATION). btn_mem -> LIVE (abort);
//   btn_rec ignored. cmd_pos holds last played pose on exit.
//  Latency: cmd_pos/cmd_valid update 1 cycle after qualifying sample_tick; state changes
//   1 cycle after button/enable. Ticks in IDLE produce no cmd_valid.
//  Reset mid-RECORD/PLAYBACK: all state above cleared; partial recording discarded.
// CONFIGURATION
//  PLAYBACK_LOOP_EN defined: after last entry rd_ptr wraps to 0 and playback repeats
//   until btn_mem or enable=0.
//  PLAYBACK_LOOP_EN undefined: after last entry state -> IDLE; rd_ptr=0.
// STRUCTURE
//  Package arm_pkg: state encoding constants (IDLE/LIVE/RECORD/PLAYBACK), mid-travel
//   default, CNT_W helper.
//  Sub-module arm_pose_mem: DEPTH x (N_JOINTS*POS_W) register array, 1 write port,
//   1 async read port; controller owns pointers and FSM.
// TESTING
//  1 reset, N_JOINTS=4,POS_W=8: cmd_pos=0x80808080, state=0, mem_count=0, err=0.
//  2 enable=1, tick, live_pos=0x11223344 -> state=LIVE, cmd_pos=0x11223344, cmd_valid 1 cycle.
//  3 btn_rec, 3 ticks with 0x01..,0x02..,0x03.., btn_rec -> mem_count=3, state=LIVE.
//  4 btn_mem, 3 ticks -> cmd_pos 0x01..,0x02..,0x03.. then IDLE (loop: 0x01.. again on 4th).
//  5 reset then btn_mem -> err pulse, state stays IDLE; btn_rec+btn_mem same cycle -> RECORD.
//  6 record DEPTH=16 ticks -> mem_count=16, auto LIVE; enable=0 mid-PLAYBACK -> IDLE, hold pose.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the arm mode controller: state encoding, mid-travel default
// and the pose-count width helper.
package arm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LIVE     = 2'd1,
    ST_RECORD   = 2'd2,
    ST_PLAYBACK = 2'd3
  } state_e;

  // Counter must hold 0..depth inclusive, hence the extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int mid_travel(input int pos_w);
    return 1 << (pos_w - 1);
  endfunction

endpackage

// File: rtl/arm_pose_mem.sv
// Pose memory: DEPTH x WIDTH register array, one synchronous write port and one
// combinational read port; no reset on contents.
module arm_pose_mem
  import arm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_dat;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/arm_mode_ctrl.sv
// Arm mode controller (IDLE/LIVE/RECORD/PLAYBACK) driving servo commands; outputs update
// 1 cycle after a qualifying sample_tick or button. Macro PLAYBACK_LOOP_EN: loop playback.
module arm_mode_ctrl
  import arm_pkg::*;
#(
  parameter int N_JOINTS = 4,
  parameter int POS_W    = 8,
  parameter int DEPTH    = 16,
  parameter int CNT_W    = cnt_width(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      btn_mem,
  input  logic                      btn_rec,
  input  logic                      sample_tick,
  input  logic [N_JOINTS*POS_W-1:0] live_pos,
  output logic [N_JOINTS*POS_W-1:0] cmd_pos,
  output logic                      cmd_valid,
  output logic [1:0]                state,
  output logic [CNT_W-1:0]          mem_count,
  output logic                      err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = N_JOINTS * POS_W;
  localparam logic [POS_W-1:0] MID = POS_W'(mid_travel(POS_W));

`ifdef PLAYBACK_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [PW-1:0]    cmd_pos_q, cmd_pos_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [CNT_W-1:0] mem_count_q, mem_count_d;
  logic             err_q, err_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;

  logic             mem_wr;
  logic [PW-1:0]    rd_dat;
  logic             mem_empty;
  logic             rec_full;
  logic             play_last;

  assign mem_empty = (mem_count_q == '0);
  assign rec_full  = (mem_count_q == CNT_W'(DEPTH - 1));
  assign play_last = ((CNT_W'(rd_ptr_q) + CNT_W'(1)) == mem_count_q);

  arm_pose_mem #(
    .WIDTH (PW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_pose_mem (
    .clk     (clk),
    .wr_en   (mem_wr),
    .wr_addr (wr_ptr_q),
    .wr_dat  (live_pos),
    .rd_addr (rd_ptr_q),
    .rd_dat  (rd_dat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cmd_pos_q   <= {N_JOINTS{MID}};
      cmd_valid_q <= 1'b0;
      mem_count_q <= '0;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_pos_q   <= cmd_pos_d;
      cmd_valid_q <= cmd_valid_d;
      mem_count_q <= mem_count_d;
      err_q       <= err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (btn_rec)                     state_d = ST_RECORD;
          else if (btn_mem && !mem_empty)  state_d = ST_PLAYBACK;
          else if (!btn_mem)               state_d = ST_LIVE;
        end
        ST_LIVE: begin
          if (btn_rec)                     state_d = ST_RECORD;
          else if (btn_mem && !mem_empty)  state_d = ST_PLAYBACK;
        end
        ST_RECORD: begin
          if (btn_rec || (sample_tick && rec_full)) state_d = ST_LIVE;
        end
        ST_PLAYBACK: begin
          if (btn_mem)                                        state_d = ST_LIVE;
          else if (sample_tick && play_last && !LOOP_EN)      state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath actions are gated by enable so a disabled arm holds its pose and memory.
  always_comb begin
    cmd_pos_d   = cmd_pos_q;
    cmd_valid_d = 1'b0;
    mem_count_d = mem_count_q;
    err_d       = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_wr      = 1'b0;
    if (enable) begin
      case (state_q)
        ST_IDLE, ST_LIVE: begin
          if (state_q == ST_LIVE && sample_tick) begin
            cmd_pos_d   = live_pos;
            cmd_valid_d = 1'b1;
          end
          if (btn_rec) begin
            wr_ptr_d    = '0;
            mem_count_d = '0;
          end else if (btn_mem) begin
            if (mem_empty) err_d    = 1'b1;
            else           rd_ptr_d = '0;
          end
        end
        ST_RECORD: begin
          if (sample_tick) begin
            mem_wr      = 1'b1;
            cmd_pos_d   = live_pos;
            cmd_valid_d = 1'b1;
            wr_ptr_d    = wr_ptr_q + AW'(1);
            mem_count_d = mem_count_q + CNT_W'(1);
          end
        end
        ST_PLAYBACK: begin
          if (sample_tick) begin
            cmd_pos_d   = rd_dat;
            cmd_valid_d = 1'b1;
            rd_ptr_d    = play_last ? '0 : rd_ptr_q + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd_pos   = cmd_pos_q;
    cmd_valid = cmd_valid_q;
    state     = state_q;
    mem_count = mem_count_q;
    err       = err_q;
  end

endmodule
